// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle controller. Defining
// MCYCLE_CTRL_STEP_EN adds the PAUSE state used for single-stepping.
package mcycle_pkg;

  localparam int WAIT_W = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERROR  = 3'd6
`ifdef MCYCLE_CTRL_STEP_EN
    , PAUSE = 3'd7
`endif
  } state_e;

  // Opcode classes; OP_HALT is the all-ones opcode of whatever width is used.
  localparam int OP_ALU   = 0;
  localparam int OP_ALUI  = 1;
  localparam int OP_LD    = 2;
  localparam int OP_ST    = 3;
  localparam int OP_BR_LO = 4;
  localparam int OP_BR_HI = 7;
  localparam int ALU_ADD  = 0;

  function automatic logic is_branch(input int unsigned op);
    return (op >= OP_BR_LO) && (op <= OP_BR_HI);
  endfunction

endpackage

// File: rtl/mcycle_wait_timer.sv
// Counts cycles spent waiting for a memory ack and flags the cycle in which
// the count would reach TIMEOUT with no ack present.
module mcycle_wait_timer
  import mcycle_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  output logic timeout
);

  logic [WAIT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (waiting && !ack) begin
      count <= count + WAIT_W'(1);
    end else begin
      count <= '0;
    end
  end

  // An ack in the cycle the limit would be reached wins over the timeout.
  assign timeout = waiting && !ack && (count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-ack watchdog. Define MCYCLE_CTRL_STEP_EN to pause after each retire.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNC_W  = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              imem_ack,
  input  logic              dmem_ack,
  input  logic              step,
  output logic              read_im,
  output logic              load_ir,
  output logic              load_npc,
  output logic              load_pc,
  output logic              load_a,
  output logic              load_b,
  output logic              load_imm,
  output logic              muxalu1,
  output logic              muxalu2,
  output logic              load_aluout,
  output logic              read_dm,
  output logic              write_dm,
  output logic              load_lmd,
  output logic              muxwb,
  output logic              write_rp,
  output logic              halted,
  output logic              mem_err,
  output logic [FUNC_W-1:0] alu_func,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  instr_count
);

`ifdef MCYCLE_CTRL_STEP_EN
  localparam state_e RETIRE_NEXT = PAUSE;
`else
  localparam state_e RETIRE_NEXT = FETCH;
  logic unused_step;
  assign unused_step = step;
`endif

  state_e state, next_state;
  logic   timeout, waiting, wait_ack;
  logic   is_alu, is_alui, is_ld, is_st, is_br, is_halt;

  assign is_alu  = (opcode == OP_W'(OP_ALU));
  assign is_alui = (opcode == OP_W'(OP_ALUI));
  assign is_ld   = (opcode == OP_W'(OP_LD));
  assign is_st   = (opcode == OP_W'(OP_ST));
  assign is_br   = is_branch(32'(opcode));
  assign is_halt = &opcode;

  assign waiting  = (state == FETCH) || (state == MEM);
  assign wait_ack = (state == MEM) ? dmem_ack : imem_ack;

  mcycle_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .ack     (wait_ack),
    .timeout (timeout)
  );

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state  = state;
    read_im     = 1'b0;
    load_ir     = 1'b0;
    load_npc    = 1'b0;
    load_pc     = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_imm    = 1'b0;
    muxalu1     = 1'b0;
    muxalu2     = 1'b0;
    load_aluout = 1'b0;
    read_dm     = 1'b0;
    write_dm    = 1'b0;
    load_lmd    = 1'b0;
    muxwb       = 1'b0;
    write_rp    = 1'b0;
    alu_func    = '0;
    // Strobes stay quiet throughout reset, whatever state is still held.
    if (!rst) begin
      case (state)
        FETCH: begin
          read_im = 1'b1;
          if (imem_ack) begin
            load_ir    = 1'b1;
            load_npc   = 1'b1;
            next_state = DECODE;
          end else if (timeout) begin
            next_state = ERROR;
          end
        end
        DECODE: begin
          load_a     = 1'b1;
          load_b     = 1'b1;
          load_imm   = 1'b1;
          next_state = EXEC;
        end
        EXEC: begin
          load_aluout = 1'b1;
          muxalu1     = is_br;
          muxalu2     = is_alui || is_ld || is_st;
          if (is_alu)                      alu_func = func;
          else if (is_alui || is_ld || is_st) alu_func = FUNC_W'(ALU_ADD);
          if (is_alu || is_alui)    next_state = WB;
          else if (is_ld || is_st)  next_state = MEM;
          else if (is_halt)         next_state = HALT;
          else begin
            load_pc    = 1'b1;
            next_state = RETIRE_NEXT;
          end
        end
        MEM: begin
          read_dm  = is_ld;
          write_dm = !is_ld;
          if (dmem_ack) begin
            if (is_ld) begin
              load_lmd   = 1'b1;
              next_state = WB;
            end else begin
              load_pc    = 1'b1;
              next_state = RETIRE_NEXT;
            end
          end else if (timeout) begin
            next_state = ERROR;
          end
        end
        WB: begin
          write_rp   = 1'b1;
          load_pc    = 1'b1;
          muxwb      = is_ld;
          next_state = RETIRE_NEXT;
        end
`ifdef MCYCLE_CTRL_STEP_EN
        PAUSE: if (step) next_state = FETCH;
`endif
        HALT, ERROR: next_state = state;
        default:     next_state = FETCH;
      endcase
    end
  end

  assign halted  = (state == HALT);
  assign mem_err = (state == ERROR);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (load_pc) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench for mcycle_ctrl: instruction-level reference model pushes
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_mcycle_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 2;

  // Bit positions in the packed output vector (same order as the port list).
  localparam int R_IM = 16, L_IR = 15, L_NPC = 14, L_PC = 13, L_A = 12, L_B = 11;
  localparam int L_IMM = 10, MUX1 = 9, MUX2 = 8, L_ALU = 7, R_DM = 6, W_DM = 5;
  localparam int L_LMD = 4, MUXWB = 3, W_RP = 2, HALTED = 1, MERR = 0;

  logic clk = 1'b1;
  logic rst, imem_ack, dmem_ack, step;
  logic [5:0] opcode;
  logic [3:0] func;
  logic read_im, load_ir, load_npc, load_pc, load_a, load_b, load_imm, muxalu1, muxalu2;
  logic load_aluout, read_dm, write_dm, load_lmd, muxwb, write_rp, halted, mem_err;
  logic [3:0] alu_func;
  logic [2:0] state_o;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  mcycle_ctrl #(.OP_W(6), .FUNC_W(4), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .step(step),
    .read_im(read_im), .load_ir(load_ir), .load_npc(load_npc), .load_pc(load_pc),
    .load_a(load_a), .load_b(load_b), .load_imm(load_imm), .muxalu1(muxalu1),
    .muxalu2(muxalu2), .load_aluout(load_aluout), .read_dm(read_dm),
    .write_dm(write_dm), .load_lmd(load_lmd), .muxwb(muxwb), .write_rp(write_rp),
    .halted(halted), .mem_err(mem_err), .alu_func(alu_func), .state_o(state_o),
    .instr_count(instr_count)
  );

  typedef struct {
    logic [16:0] vec;
    logic [16:0] mask;
    bit          chk_st;
    bit          fetch;
    bit          chk_cnt;
    int          cnt;
    logic [3:0]  func;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0, mdl_cnt = 0, cyc_n = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] expv);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, expv);
  endtask

  // Monitor: one expected record per clock cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [16:0] act;
      e = exp_q.pop_front();
      act = {read_im, load_ir, load_npc, load_pc, load_a, load_b, load_imm, muxalu1,
             muxalu2, load_aluout, read_dm, write_dm, load_lmd, muxwb, write_rp,
             halted, mem_err};
      check("strobes", (act & e.mask) == (e.vec & e.mask), 32'(act & e.mask), 32'(e.vec & e.mask));
      check("alu_func", alu_func == e.func, 32'(alu_func), 32'(e.func));
      if (e.chk_st)
        check("state_fetch", (state_o == 3'd0) == e.fetch, 32'(state_o), 32'(e.fetch));
      if (e.chk_cnt)
        check("instr_count", instr_count == CNT_W'(e.cnt), 32'(instr_count), 32'(e.cnt));
      cyc_n++;
    end
  end

  function automatic exp_t mk(input bit fetch);
    exp_t e;
    e.vec = '0;
    e.mask = ~(17'b1 << MUX1);
    e.chk_st = 1'b1;
    e.fetch = fetch;
    e.chk_cnt = 1'b1;
    e.cnt = mdl_cnt;
    e.func = '0;
    return e;
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input bit r, input bit ia, input bit da, input exp_t e);
    rst = r;
    imem_ack = ia;
    dmem_ack = da;
    step = rnd();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    mdl_cnt = (mdl_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = mk(1'b0);
    e.mask[HALTED] = 1'b0;
    e.mask[MERR] = 1'b0;
    e.chk_st = 1'b0;
    e.chk_cnt = 1'b0;
    cyc(1'b1, rnd(), rnd(), e);
    mdl_cnt = 0;
    for (int i = 1; i < n; i++) cyc(1'b1, rnd(), rnd(), mk(1'b1));
  endtask

  task automatic sticky(input int bitpos, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = mk(1'b0);
      e.vec[bitpos] = 1'b1;
      cyc(1'b0, rnd(), rnd(), e);
    end
  endtask

  // Expands one instruction into its expected cycle-by-cycle outputs.
  // di/dd: cycles before imem/dmem ack; >= TO means the ack never comes.
  task automatic run_instr(input int op, input int fn, input int di, input int dd);
    exp_t e;
    bit   ack;
    bit   mem_op = (op == 2) || (op == 3);
    bit   wb_op = (op <= 2) && (op != 1 || 1'b1) && (op != 3) ;
    int   nf = (di < TO) ? di + 1 : TO;
    int   nm = (dd < TO) ? dd + 1 : TO;
    opcode = 6'(op);
    func = 4'(fn);
    for (int k = 0; k < nf; k++) begin
      e = mk(1'b1);
      e.vec[R_IM] = 1'b1;
      ack = (k == di);
      e.vec[L_IR] = ack;
      e.vec[L_NPC] = ack;
      cyc(1'b0, ack, rnd(), e);
    end
    if (di >= TO) begin sticky(MERR, 8); return; end
    e = mk(1'b0);
    e.vec[L_A] = 1'b1; e.vec[L_B] = 1'b1; e.vec[L_IMM] = 1'b1;
    cyc(1'b0, rnd(), rnd(), e);
    e = mk(1'b0);
    e.vec[L_ALU] = 1'b1;
    e.vec[MUX2] = (op >= 1) && (op <= 3);
    e.func = (op == 0) ? 4'(fn) : 4'd0;
    if (op == 63) begin
      cyc(1'b0, rnd(), rnd(), e);
      sticky(HALTED, 20);
      return;
    end
    if (op > 3) begin
      e.vec[L_PC] = 1'b1;
      cyc(1'b0, rnd(), rnd(), e);
      retire();
      return;
    end
    cyc(1'b0, rnd(), rnd(), e);
    if (mem_op) begin
      for (int k = 0; k < nm; k++) begin
        e = mk(1'b0);
        ack = (k == dd);
        if (op == 2) begin e.vec[R_DM] = 1'b1; e.vec[L_LMD] = ack; end
        else         begin e.vec[W_DM] = 1'b1; e.vec[L_PC] = ack; end
        cyc(1'b0, rnd(), ack, e);
      end
      if (dd >= TO) begin sticky(MERR, 8); return; end
      if (op == 3) begin retire(); return; end
    end
    if (wb_op || op == 1) begin
      e = mk(1'b0);
      e.vec[W_RP] = 1'b1; e.vec[L_PC] = 1'b1; e.vec[MUXWB] = (op == 2);
      cyc(1'b0, rnd(), rnd(), e);
      retire();
    end
  endtask

  function automatic int rand_op();
    int r = $urandom_range(0, 9);
    if (r <= 3) return r;
    if (r <= 5) return 4 + $urandom_range(0, 3);
    if (r == 6) return $urandom_range(8, 62);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    exp_t e;
    opcode = '0; func = '0;
    do_reset(3);
    for (int i = 0; i < 5; i++) run_instr(4 + i % 4, $urandom_range(0, 15), 0, 0);
    run_instr(0, 5, 0, 0);
    run_instr(2, 9, 0, 3);
    run_instr(3, 2, 0, 0);
    run_instr(1, 7, TO - 1, 0);
    for (int i = 0; i < 60; i++)
      run_instr(rand_op(), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
    // Reset in the middle of an instruction fetch wait.
    for (int k = 0; k < 2; k++) begin
      e = mk(1'b1);
      e.vec[R_IM] = 1'b1;
      cyc(1'b0, 1'b0, rnd(), e);
    end
    do_reset(2);
    run_instr(3, 1, TO - 1, TO - 1);
    run_instr(63, 0, 1, 0);
    do_reset(2);
    run_instr(2, 4, 0, TO);
    do_reset(2);
    run_instr(0, 3, TO, 0);
    do_reset(2);
    run_instr(0, 12, 2, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have parameter OP_W, 6, opcode width.
REQ-002 SHALL have parameter FUNC_W, 4, ALU function width.
REQ-003 SHALL have parameter TIMEOUT, 15, max wait cycles for a memory ack (1..255).
REQ-004 SHALL have parameter CNT_W, 16, retired-instruction counter width.
REQ-005 SHALL have ports, clock and reset first: clk input 1 system clock; rst input 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: opcode input OP_W IR opcode; func input FUNC_W IR function; imem_ack input 1 instruction fetch done; dmem_ack input 1 data access done; step input 1 single-step pulse (macro only).
REQ-007 SHALL have outputs, all 1 bit: read_im, load_ir, load_npc, load_pc, load_a, load_b, load_imm, muxalu1, muxalu2, load_aluout, read_dm, write_dm, load_lmd, muxwb, write_rp, halted, mem_err.
REQ-008 SHALL have outputs: alu_func output FUNC_W; state_o output 3 current state; instr_count output CNT_W retired count.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR (plus PAUSE under macro).
REQ-010 FETCH: read_im=1; on imem_ack in the same cycle pulse load_ir and load_npc, then DECODE.
REQ-011 DECODE: load_a, load_b, load_imm=1 for one cycle, then EXEC.
REQ-012 EXEC: load_aluout=1; alu_func=func for OP_ALU, ADD code for OP_ALUI/OP_LD/OP_ST, 0 otherwise; muxalu2=1 for immediate classes.
REQ-013 EXEC next state: OP_ALU/OP_ALUI -> WB; OP_LD/OP_ST -> MEM; OP_BR (opcode 4..7) -> pulse load_pc, FETCH; OP_HALT -> HALT; any other opcode -> FETCH as NOP with load_pc.
REQ-014 MEM: hold read_dm (LD) or write_dm (ST) until dmem_ack; on ack LD pulses load_lmd -> WB, ST pulses load_pc -> FETCH.
REQ-015 WB: write_rp=1, load_pc=1, muxwb=1 for LD else 0; then FETCH.
REQ-016 SHALL increment instr_count by one on every load_pc pulse; wraps modulo 2^CNT_W.
REQ-017 A 8-bit wait counter SHALL clear on entering FETCH/MEM and increment each cycle without ack; reaching TIMEOUT without ack -> ERROR.
REQ-018 ERROR: mem_err=1, all load/read/write strobes 0, sticky until rst.
REQ-019 HALT: halted=1, all strobes 0, sticky until rst.
REQ-020 Zero-wait latency SHALL be 4 cycles ALU, 5 cycles LD, 4 cycles ST, 3 cycles branch.
REQ-021 Ack in the same cycle the wait counter reaches TIMEOUT SHALL win; no ERROR.
REQ-022 Acks arriving in states not waiting on them SHALL be ignored.

Reset
REQ-023 rst SHALL force FETCH, wait counter 0, instr_count 0, mem_err 0, halted 0 at the next clk edge, including mid-wait.
REQ-024 During rst all strobes SHALL be 0 and state_o SHALL read FETCH encoding 0 from the following cycle.

Configuration
REQ-025 Macro MCYCLE_CTRL_STEP_EN defined: after each load_pc pulse enter PAUSE (strobes 0) and return to FETCH on the cycle after step=1; step in other states ignored.
REQ-026 Macro undefined: no PAUSE state, step port present but ignored, behaviour per REQ-009..022.

Structure
REQ-027 Shared package mcycle_pkg SHALL hold the state enum, opcode class constants (OP_ALU=0, OP_ALUI=1, OP_LD=2, OP_ST=3, OP_BR=4..7, OP_HALT=all-ones) and ALU ADD code=0.
REQ-028 Sub-module mcycle_wait_timer SHALL hold the wait counter and timeout compare.

Verification
REQ-029 OP_ALU, func=5, acks tied 1 -> alu_func=5 in EXEC, write_rp at cycle 4, instr_count=1.
REQ-030 OP_LD, dmem_ack delayed 3 cycles -> read_dm held 4 cycles, load_lmd once, muxwb=1, 8 total cycles.
REQ-031 TIMEOUT=4, imem_ack never -> ERROR after 4 wait cycles, mem_err=1 until rst.
REQ-032 OP_HALT -> halted=1 from cycle 4, strobes 0 for 20 cycles; rst -> FETCH, halted=0.
REQ-033 CNT_W=2, 5 branches -> instr_count reads 1,2,3,0,1.
REQ-034 With MCYCLE_CTRL_STEP_EN, ALU instr -> PAUSE; no fetch until step pulse, FETCH next cycle.
